// File: rtl/led_sequencer.sv
// LED script sequencer: queues (op, duration) entries and plays them
// onto the dev_led op input, falling back to an idle op when empty.
package pkg_led;
    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_FLASH = 2'd3
    } led_op_t;
endpackage

module led_sequencer #(
    parameter int CLK_FREQ = 12_000_000,
    parameter int DEPTH    = 8,
    parameter int DUR_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  pkg_led::led_op_t         push_op,
    input  logic [DUR_W-1:0]         push_dur,
    input  pkg_led::led_op_t         idle_op,
    input  logic                     flush,
    output pkg_led::led_op_t         led_op,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     done
);
    import pkg_led::*;

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int P  = CLK_FREQ / 1000;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(P - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [PW-1:0]    presc;
    logic [DUR_W-1:0] remaining;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    led_op_t          mem_op  [DEPTH];
    logic [DUR_W-1:0] mem_dur [DEPTH];

    logic             push_fire;
    logic             pop;
    logic             ms_tick;
    led_op_t          head_op;
    logic [DUR_W-1:0] head_dur;

    // Readiness uses the registered level only, so a same-cycle pop never
    // frees a slot for the push.
    assign push_ready = (level < LW'(DEPTH)) && !flush;
    assign push_fire  = push_valid && push_ready;
    assign ms_tick    = (state == RUN) && (presc == P_LAST);
    assign head_op    = mem_op[rd_ptr];
    assign head_dur   = mem_dur[rd_ptr];

    // remaining == 0 marks a persistent entry, superseded by any queued one.
    always_comb begin
        pop = 1'b0;
        if (!rst && !flush && level != '0) begin
            unique case (state)
                IDLE:    pop = 1'b1;
                RUN:     pop = (remaining == '0) ||
                               (ms_tick && remaining == DUR_W'(1));
                default: pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem_op[wr_ptr]  <= push_op;
            mem_dur[wr_ptr] <= push_dur;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_fire)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push_fire) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            led_op    <= LED_OFF;
            busy      <= 1'b0;
            done      <= 1'b0;
            presc     <= '0;
            remaining <= '0;
        end else if (flush) begin
            state  <= IDLE;
            led_op <= idle_op;
            busy   <= 1'b0;
            done   <= (state == RUN);
            presc  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    presc  <= '0;
                    led_op <= idle_op;
                end
                RUN: begin
                    presc <= ms_tick ? '0 : presc + 1'b1;
                    if (remaining == '0) begin
                        done <= pop;
                    end else if (ms_tick) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == DUR_W'(1)) begin
                            done   <= 1'b1;
                            state  <= IDLE;
                            busy   <= 1'b0;
                            led_op <= idle_op;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // A load overrides whatever the state arm scheduled above.
            if (pop) begin
                state     <= RUN;
                busy      <= 1'b1;
                led_op    <= head_op;
                remaining <= head_dur;
                presc     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: cycle-level queue model plus directed
// scripts with hand-computed expectations and a randomized run.
`timescale 1ns/1ps
module tb_led_sequencer;
    import pkg_led::*;

    localparam int CLK_FREQ = 4000;
    localparam int DEPTH    = 4;
    localparam int DUR_W    = 16;
    localparam int CPM      = CLK_FREQ / 1000;
    localparam int N        = 128;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             push_valid = 1'b0;
    logic             push_ready;
    led_op_t          push_op = LED_OFF;
    logic [DUR_W-1:0] push_dur = '0;
    led_op_t          idle_op = LED_OFF;
    logic             flush = 1'b0;
    led_op_t          led_op;
    logic             busy;
    logic [2:0]       level;
    logic             done;

    led_sequencer #(
        .CLK_FREQ(CLK_FREQ),
        .DEPTH(DEPTH),
        .DUR_W(DUR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .push_valid(push_valid),
        .push_ready(push_ready),
        .push_op(push_op),
        .push_dur(push_dur),
        .idle_op(idle_op),
        .flush(flush),
        .led_op(led_op),
        .busy(busy),
        .level(level),
        .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: a queue of pending entries plus the active one, whose
    // remaining display time is counted in clock cycles.
    typedef struct {
        led_op_t op;
        int      dur;
    } ent_t;

    ent_t    q[$];
    bit      m_act = 0;
    bit      m_pers = 0;
    int      m_left = 0;
    led_op_t m_led = LED_OFF;
    bit      m_done = 0;
    bit      m_take;
    bit      m_accept;
    ent_t    m_e;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_act  = 0;
            m_led  = LED_OFF;
            m_done = 0;
        end else if (flush) begin
            m_done = m_act;
            m_act  = 0;
            q.delete();
            m_led  = idle_op;
        end else begin
            m_accept = push_valid && (q.size() < DEPTH);
            m_take   = 0;
            m_done   = 0;
            if (!m_act) begin
                if (q.size() > 0) m_take = 1;
                else m_led = idle_op;
            end else if (m_pers) begin
                if (q.size() > 0) begin
                    m_take = 1;
                    m_done = 1;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1;
                    if (q.size() > 0) m_take = 1;
                    else begin
                        m_act = 0;
                        m_led = idle_op;
                    end
                end
            end
            if (m_take) begin
                m_e    = q.pop_front();
                m_act  = 1;
                m_led  = m_e.op;
                m_pers = (m_e.dur == 0);
                m_left = m_e.dur * CPM;
            end
            if (m_accept)
                q.push_back('{push_op, int'(push_dur)});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("led_op", led_op, m_led);
            chk("busy", busy, m_act);
            chk("done", done, m_done);
            chk("level", level, q.size());
            chk("push_ready", push_ready,
                (q.size() < DEPTH) && !flush);
        end
    end

    bit      s_v  [N];
    bit      s_fl [N];
    bit      s_rs [N];
    led_op_t s_op [N];
    int      s_dur[N];
    led_op_t h_led  [N];
    int      h_done [N];
    int      h_level[N];
    int      h_rdy  [N];
    int      h_busy [N];

    task automatic clear_script();
        for (int i = 0; i < N; i++) begin
            s_v[i]   = 0;
            s_fl[i]  = 0;
            s_rs[i]  = 0;
            s_op[i]  = LED_OFF;
            s_dur[i] = 0;
        end
    endtask

    task automatic put(input int k, input led_op_t op, input int dur);
        s_v[k]   = 1;
        s_op[k]  = op;
        s_dur[k] = dur;
    endtask

    task automatic play(input int n);
        for (int k = 0; k < n; k++) begin
            push_valid = s_v[k];
            push_op    = s_op[k];
            push_dur   = DUR_W'(s_dur[k]);
            flush      = s_fl[k];
            rst        = s_rs[k];
            @(negedge clk);
            h_led[k]   = led_op;
            h_done[k]  = int'(done);
            h_level[k] = int'(level);
            h_rdy[k]   = int'(push_ready);
            h_busy[k]  = int'(busy);
            @(posedge clk);
            #2;
        end
        push_valid = 0;
        flush      = 0;
        rst        = 0;
    endtask

    function automatic int cnt_led(input int a, input int b,
                                   input led_op_t v);
        int c = 0;
        for (int i = a; i <= b; i++)
            if (h_led[i] == v) c++;
        return c;
    endfunction

    function automatic int cnt_done(input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++)
            c += h_done[i];
        return c;
    endfunction

    initial begin
        @(posedge clk);
        #2;
        chk_en = 1;
        @(negedge clk);
        chk("rst_led", led_op, LED_OFF);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        #2;
        rst = 0;
        idle_op = LED_BLINK;
        @(posedge clk);
        #2;
        chk("post_rst_led", led_op, LED_BLINK);

        // basic entry
        idle_op = LED_OFF;
        @(posedge clk);
        #2;
        clear_script();
        put(0, LED_ON, 3);
        play(20);
        chk("basic_on_cycles", cnt_led(0, 19, LED_ON), 12);
        chk("basic_before", h_led[1], LED_OFF);
        chk("basic_first", h_led[2], LED_ON);
        chk("basic_last", h_led[13], LED_ON);
        chk("basic_after", h_led[14], LED_OFF);
        chk("basic_done_at", h_done[14], 1);
        chk("basic_done_cnt", cnt_done(0, 19), 1);
        chk("basic_busy_end", h_busy[15], 0);

        // back-to-back
        clear_script();
        put(0, LED_ON, 1);
        put(1, LED_BLINK, 2);
        put(2, LED_FLASH, 1);
        play(22);
        chk("b2b_on", cnt_led(0, 21, LED_ON), 4);
        chk("b2b_blink", cnt_led(0, 21, LED_BLINK), 8);
        chk("b2b_flash", cnt_led(0, 21, LED_FLASH), 4);
        chk("b2b_edge1", h_led[6], LED_BLINK);
        chk("b2b_edge2", h_led[14], LED_FLASH);
        chk("b2b_idle", h_led[18], LED_OFF);
        chk("b2b_done", cnt_done(0, 21), 3);
        chk("b2b_level", h_level[3], 2);

        // full FIFO, including a pop in the same cycle as a push
        clear_script();
        put(0, LED_ON, 10);
        for (int k = 2; k <= 45; k++)
            put(k, LED_BLINK, 1);
        play(70);
        chk("full_level", h_level[6], 4);
        chk("full_ready", h_rdy[6], 0);
        chk("full_on_len", cnt_led(2, 41, LED_ON), 40);
        chk("full_pop_ready", h_rdy[41], 0);
        chk("full_pop_level", h_level[42], 3);
        chk("full_ready_again", h_rdy[42], 1);
        chk("full_refill", h_level[43], 4);
        chk("full_next_op", h_led[42], LED_BLINK);

        // persistent entry
        idle_op = LED_BLINK;
        clear_script();
        put(0, LED_ON, 0);
        put(100, LED_OFF, 1);
        play(110);
        chk("pers_hold", cnt_led(2, 101, LED_ON), 100);
        chk("pers_switch", h_led[102], LED_OFF);
        chk("pers_done_at", h_done[102], 1);
        chk("pers_done_cnt", cnt_done(0, 105), 1);
        chk("pers_idle", h_led[106], LED_BLINK);
        chk("pers_busy_end", h_busy[106], 0);

        // flush with a simultaneous push
        idle_op = LED_FLASH;
        clear_script();
        put(0, LED_ON, 5);
        put(1, LED_BLINK, 1);
        put(2, LED_BLINK, 2);
        put(5, LED_OFF, 1);
        s_fl[5] = 1;
        play(15);
        chk("flush_level_pre", h_level[5], 2);
        chk("flush_ready", h_rdy[5], 0);
        chk("flush_level", h_level[6], 0);
        chk("flush_done", h_done[6], 1);
        chk("flush_led", h_led[6], LED_FLASH);
        chk("flush_busy", h_busy[6], 0);
        chk("flush_no_more", cnt_done(7, 14), 0);
        chk("flush_dropped", h_level[8], 0);

        // reset while running
        clear_script();
        put(0, LED_ON, 5);
        put(1, LED_BLINK, 1);
        put(2, LED_BLINK, 1);
        s_rs[4] = 1;
        play(10);
        chk("rst_mid_level_pre", h_level[4], 2);
        chk("rst_mid_busy_pre", h_busy[4], 1);
        chk("rst_mid_led", h_led[5], LED_OFF);
        chk("rst_mid_level", h_level[5], 0);
        chk("rst_mid_busy", h_busy[5], 0);
        chk("rst_mid_done", h_done[5], 0);
        chk("rst_mid_idle", h_led[6], LED_FLASH);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            push_valid = ($urandom_range(0, 9) < 4);
            push_op    = led_op_t'($urandom_range(0, 3));
            push_dur   = DUR_W'($urandom_range(0, 3));
            flush      = ($urandom_range(0, 99) < 2);
            rst        = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 19) == 0)
                idle_op = led_op_t'($urandom_range(0, 3));
            @(posedge clk);
            #2;
        end
        push_valid = 0;
        flush      = 0;
        rst        = 0;
        @(negedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
